// File: rtl/rot3_sched.sv
// rot3_sched: command sequencer for a three-register rotation bank.
// Commands arrive on a valid/ready handshake and are accepted only in IDLE.
// LOAD and CLEAR act on the accept edge. A rotation of N steps applies one
// concurrent step per clock in RUN. Every command ends with a one-cycle DONE
// state, and that state drives the done pulse.
module rot3_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic [WIDTH-1:0] load_c,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done
);

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_ROT_FWD = 2'b01;
    localparam logic [1:0] OP_ROT_REV = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             dir_rev;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_c;

    // Status outputs are decoded from the state register only, so they never depend combinationally on inputs
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign a_out      = reg_a;
    assign b_out      = reg_b;
    assign c_out      = reg_c;
    assign steps_done = steps;

    // Sequencer FSM and rotation bank: accept in IDLE, step once per clock in RUN, then pulse DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir_rev   <= 1'b0;
            remaining <= '0;
            steps     <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        steps <= '0;
                        case (cmd_op)
                            OP_LOAD: begin
                                reg_a <= load_a;
                                reg_b <= load_b;
                                reg_c <= load_c;
                                state <= DONE;
                            end
                            OP_CLEAR: begin
                                reg_a <= '0;
                                reg_b <= '0;
                                reg_c <= '0;
                                state <= DONE;
                            end
                            OP_ROT_FWD, OP_ROT_REV: begin
                                // A zero-step rotation completes without touching the bank
                                if (cmd_count == '0) begin
                                    state <= DONE;
                                end else begin
                                    dir_rev   <= (cmd_op == OP_ROT_REV);
                                    remaining <= cmd_count;
                                    state     <= RUN;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RUN: begin
                    // All right-hand sides are pre-edge values, so this is a true concurrent rotation
                    if (dir_rev) begin
                        reg_a <= reg_c;
                        reg_b <= reg_a;
                        reg_c <= reg_b;
                    end else begin
                        reg_a <= reg_b;
                        reg_b <= reg_c;
                        reg_c <= reg_a;
                    end
                    remaining <= remaining - 1'b1;
                    steps     <= steps + 1'b1;
                    if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot3_sched.sv
// tb_rot3_sched: directed vectors with hand-computed expectations for rot3_sched.
module tb_rot3_sched;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [7:0] load_a;
    logic [7:0] load_b;
    logic [7:0] load_c;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] c_out;
    logic       busy;
    logic       done;
    logic [3:0] steps_done;

    int vectors;
    int miscompares;

    rot3_sched #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_c     (load_c),
        .a_out      (a_out),
        .b_out      (b_out),
        .c_out      (c_out),
        .busy       (busy),
        .done       (done),
        .steps_done (steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bound the whole run so a stuck bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] abc();
        return {8'h00, a_out, b_out, c_out};
    endfunction

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single accept edge; returns in the cycle after that edge
    task automatic issue(input logic [1:0] op, input logic [3:0] cnt,
                         input logic [7:0] la, input logic [7:0] lb, input logic [7:0] lc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        load_a    = la;
        load_b    = lb;
        load_c    = lc;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_count   = 4'd0;
        load_a      = 8'd0;
        load_b      = 8'd0;
        load_c      = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_abc",   abc(),              32'h000000);
        chk("rst_ready", 32'(cmd_ready),     32'd1);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_steps", 32'(steps_done),    32'd0);
        rst_n = 1'b1;
        tick();

        // LOAD 5,10,0
        issue(2'b00, 4'd0, 8'd5, 8'd10, 8'd0);
        chk("load_abc",   abc(),          32'h050A00);
        chk("load_done",  32'(done),      32'd1);
        chk("load_ready", 32'(cmd_ready), 32'd0);
        chk("load_steps", 32'(steps_done), 32'd0);
        tick();
        chk("load_done_off", 32'(done),      32'd0);
        chk("load_ready_on", 32'(cmd_ready), 32'd1);

        // ROT_FWD 1: 5/10/0 -> 10/0/5
        issue(2'b01, 4'd1, 8'd0, 8'd0, 8'd0);
        chk("f1_busy",   32'(busy), 32'd1);
        chk("f1_hold",   abc(),     32'h050A00);
        tick();
        chk("f1_abc",    abc(),           32'h0A0005);
        chk("f1_steps",  32'(steps_done), 32'd1);
        chk("f1_done",   32'(done),       32'd1);
        chk("f1_busy_off", 32'(busy),     32'd0);
        tick();
        chk("f1_ready",  32'(cmd_ready),  32'd1);
        chk("f1_steps_hold", 32'(steps_done), 32'd1);

        // Reload then ROT_FWD 3: passes 10/0/5, 0/5/10, back to 5/10/0
        issue(2'b00, 4'd0, 8'd5, 8'd10, 8'd0);
        tick();
        issue(2'b01, 4'd3, 8'd0, 8'd0, 8'd0);
        chk("f3_busy0", 32'(busy), 32'd1);
        chk("f3_done0", 32'(done), 32'd0);
        chk("f3_steps0", 32'(steps_done), 32'd0);
        tick();
        chk("f3_abc1",  abc(),      32'h0A0005);
        chk("f3_busy1", 32'(busy),  32'd1);
        tick();
        chk("f3_abc2",  abc(),      32'h00050A);
        chk("f3_busy2", 32'(busy),  32'd1);
        chk("f3_steps2", 32'(steps_done), 32'd2);
        tick();
        chk("f3_abc3",  abc(),           32'h050A00);
        chk("f3_done3", 32'(done),       32'd1);
        chk("f3_busy3", 32'(busy),       32'd0);
        chk("f3_steps3", 32'(steps_done), 32'd3);
        tick();
        chk("f3_ready", 32'(cmd_ready), 32'd1);
        chk("f3_done_off", 32'(done),   32'd0);

        // ROT_REV 1: 5/10/0 -> 0/5/10, then ROT_FWD 1 restores
        issue(2'b10, 4'd1, 8'd0, 8'd0, 8'd0);
        tick();
        chk("r1_abc",  abc(),     32'h00050A);
        chk("r1_done", 32'(done), 32'd1);
        tick();
        issue(2'b01, 4'd1, 8'd0, 8'd0, 8'd0);
        tick();
        chk("r1f1_abc", abc(), 32'h050A00);
        tick();

        // ROT_FWD count 0: immediate done, no register change
        issue(2'b01, 4'd0, 8'd0, 8'd0, 8'd0);
        chk("f0_abc",   abc(),           32'h050A00);
        chk("f0_done",  32'(done),       32'd1);
        chk("f0_steps", 32'(steps_done), 32'd0);
        chk("f0_busy",  32'(busy),       32'd0);
        tick();

        // CLEAR
        issue(2'b11, 4'd0, 8'd0, 8'd0, 8'd0);
        chk("clr_abc",  abc(),     32'h000000);
        chk("clr_done", 32'(done), 32'd1);
        tick();

        // ROT_FWD 7 with a LOAD held on the bus throughout the run
        issue(2'b00, 4'd0, 8'd5, 8'd10, 8'd0);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 4'd7;
        tick();
        cmd_op    = 2'b00;
        cmd_count = 4'd2;
        load_a    = 8'hFF;
        load_b    = 8'hFF;
        load_c    = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("f7_ready%0d", k), 32'(cmd_ready), 32'd0);
            chk($sformatf("f7_done%0d", k),  32'(done),      32'd0);
        end
        tick();
        cmd_valid = 1'b0;
        chk("f7_done",  32'(done),       32'd1);
        chk("f7_ready", 32'(cmd_ready),  32'd0);
        chk("f7_steps", 32'(steps_done), 32'd7);
        chk("f7_abc",   abc(),           32'h0A0005);
        tick();
        chk("f7_ready_on", 32'(cmd_ready), 32'd1);
        chk("f7_abc_hold", abc(),          32'h0A0005);

        // ROT_FWD 5 aborted by reset after step 2
        issue(2'b00, 4'd0, 8'd5, 8'd10, 8'd0);
        tick();
        issue(2'b01, 4'd5, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("ab_abc2", abc(), 32'h00050A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_abc",   abc(),           32'h000000);
        chk("ab_ready", 32'(cmd_ready),  32'd1);
        chk("ab_busy",  32'(busy),       32'd0);
        chk("ab_done",  32'(done),       32'd0);
        chk("ab_steps", 32'(steps_done), 32'd0);
        tick();
        chk("ab_done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ab_done_after", 32'(done),      32'd0);
        chk("ab_ready_after", 32'(cmd_ready), 32'd1);
        chk("ab_abc_after",  abc(),          32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rot3_sched.md
Name: rot3_sched

Overview:
- Command-driven sequencer for a three-register rotation datapath (registers A, B, C).
- Accepts load, clear, forward-rotate and reverse-rotate commands over a valid/ready handshake.
- Executes a commanded number of rotation steps, one per clock. All three registers update concurrently at each step.
- Sits between a host/testbench driver and the rotation bank. It owns the bank's registers and reports completion.

Parameters:
- WIDTH, 8, data width of each of the registers A, B, C.
- CNT_W, 4, width of the step-count field. Maximum steps per command is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command. High only in IDLE.
- cmd_op  input  2  00=LOAD, 01=ROT_FWD, 10=ROT_REV, 11=CLEAR.
- cmd_count  input  CNT_W  number of rotation steps. Used by ROT_* only.
- load_a  input  WIDTH  LOAD value for A.
- load_b  input  WIDTH  LOAD value for B.
- load_c  input  WIDTH  LOAD value for C.
- a_out  output  WIDTH  current A.
- b_out  output  WIDTH  current B.
- c_out  output  WIDTH  current C.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on command completion.
- steps_done  output  CNT_W  steps executed by the current/last command.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_out=b_out=c_out=0, steps_done=0, remaining-step counter=0.
  - State=IDLE, busy=0, done=0.
  - cmd_ready=1, since it is decoded from state==IDLE.
- States: IDLE, RUN, DONE.
- Acceptance happens on the rising edge where cmd_valid && cmd_ready. cmd_valid outside IDLE is ignored: no queueing, no error.
- On the accept edge, for every op: steps_done<=0.
- LOAD: at the accept edge A<=load_a, B<=load_b, C<=load_c. Next state DONE.
- CLEAR: at the accept edge A,B,C<=0. Next state DONE.
- ROT_FWD / ROT_REV with cmd_count=0: no register change. Next state DONE.
- ROT_FWD / ROT_REV with cmd_count=N>0:
  - At the accept edge: latch direction, remaining<=N. Next state RUN.
  - Registers do not change on the accept edge.
- RUN, at each rising edge:
  - Perform exactly one step.
  - remaining<=remaining-1, steps_done<=steps_done+1.
  - If remaining==1 before the edge, next state is DONE; otherwise stay in RUN.
- Forward step: A<=B, B<=C, C<=A. All right-hand sides are pre-edge values, i.e. a true concurrent swap with no intermediate values.
- Reverse step: A<=C, B<=A, C<=B. Reverse is the exact inverse of forward.
- Latency:
  - For an N-step command accepted at edge 0, step k lands at edge k.
  - done=1 during the cycle after edge N.
  - cmd_ready returns high one cycle later.
  - LOAD, CLEAR and count-0 commands: done during the cycle after the accept edge.
- DONE state: done=1, cmd_ready=0, busy=0. The block unconditionally returns to IDLE on the next edge.
- done is registered/state-decoded and never combinationally dependent on inputs.
- steps_done holds its final value until the next accept. Wrap is impossible because N≤2^CNT_W-1.
- Direction and count are latched at acceptance. Changes on cmd_op/cmd_count during RUN have no effect.
- A reset asserted mid-RUN aborts immediately: registers cleared, no done pulse.
- An N=3 forward or reverse rotation restores the original A,B,C.

Test Plan:
- Reset, then LOAD 5,10,0 → next cycle a/b/c=5/10/0, done=1 for exactly one cycle, then cmd_ready=1.
- From 5/10/0, ROT_FWD count=1 → after edge 1 a/b/c=10/0/5, steps_done=1. With count=3 instead → 5/10/0 again, done in cycle 4, busy high for cycles 1–3.
- From 5/10/0, ROT_REV count=1 → 0/5/10. Follow with ROT_FWD count=1 → 5/10/0 restored.
- ROT_FWD count=0 → no register change, done next cycle, steps_done=0. Then CLEAR → 0/0/0.
- During a ROT_FWD count=7 run, hold cmd_valid=1 with op=LOAD → ignored. Exactly 7 steps occur (state equals 1 step mod 3), and cmd_ready stays 0 until after done.
- From 5/10/0, ROT_FWD count=5 with rst_n pulsed low after step 2 → outputs 0/0/0 asynchronously, state IDLE, no done pulse, cmd_ready=1.
